axi_wr_router: RTL and testbench
================================

AXI_WR_ROUTER -- requirements
Module: axi_wr_router

Interface
REQ-001 Parameter: S1_WIDTH, 32'h8000_0000, base of slave-2 region (must match the address decoder).
REQ-002 Port: clk  input  1  single clock; all state on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Ports (master AW): m_awaddr in 32; m_awlen in 8, beats-1; m_awvalid in 1; m_awready out 1.
REQ-005 Ports (master W): m_wdata in 32; m_wstrb in 4; m_wlast in 1; m_wvalid in 1; m_wready out 1.
REQ-006 Ports (master B): m_bresp out 2; m_bvalid out 1; m_bready in 1.
REQ-007 Ports (decoder link): dec_wr_addr out 32, drives decoder wr_addr; dec_s1_sel in 1; dec_s2_sel in 1; dec_s1_addr in 32; dec_s2_addr in 32.
REQ-008 Ports (per slave, prefix s1_ and s2_): awaddr out 32; awlen out 8; awvalid out 1; awready in 1; wdata out 32; wstrb out 4; wlast out 1; wvalid out 1; wready in 1; bresp in 2; bvalid in 1; bready out 1.

Function
REQ-009 dec_wr_addr SHALL equal m_awaddr combinationally at all times.
REQ-010 FSM states SHALL be IDLE, ADDR, DATA, RESP; exactly one transaction outstanding.
REQ-011 IDLE: m_awready=1; on m_awvalid&&m_awready, latch sel (1=slave2 when dec_s2_sel), translated address (dec_s1_addr or dec_s2_addr), m_awlen; clear beat counter; go to ADDR.
REQ-012 ADDR: selected sX_awvalid=1 with latched awaddr/awlen, asserted the cycle after capture; hold until sX_awready; then go to DATA.
REQ-013 DATA: selected sX_wdata/wstrb/wvalid = m_wdata/m_wstrb/m_wvalid; m_wready = selected sX_wready; zero-latency pass-through.
REQ-014 DATA: sX_wlast SHALL be generated as (beat_cnt == latched awlen), not forwarded from m_wlast.
REQ-015 beat_cnt (8 bit) SHALL increment on each W handshake; on handshake with beat_cnt == awlen go to RESP.
REQ-016 awlen=0: single beat; DATA exits after first handshake. awlen=255: 256 beats, counter never wraps past 255.
REQ-017 RESP: m_bvalid = selected sX_bvalid; m_bresp = selected sX_bresp; selected sX_bready = m_bready; on handshake go to IDLE.
REQ-018 Unselected slave valid/ready outputs SHALL be 0 in every state; all slave valids 0 in IDLE.
REQ-019 m_awready SHALL be 0 outside IDLE; m_wready 0 outside DATA; m_bvalid 0 outside RESP.
REQ-020 Back-to-back: new AW SHALL be accepted in the cycle IDLE is re-entered (one idle cycle after B handshake minimum).
REQ-021 Address exactly S1_WIDTH SHALL route to slave 2 with translated address 0; S1_WIDTH-1 routes to slave 1 untranslated.

Reset
REQ-022 rst high SHALL asynchronously force IDLE, beat_cnt=0, latched sel/addr/len=0, error flag=0.
REQ-023 During reset all valid/ready outputs SHALL be 0 except none; m_awready SHALL be 0 while rst is high and 1 from the first clock with rst low.
REQ-024 Reset mid-transaction SHALL abandon the transaction; no slave valid asserted after reset release until a new AW handshake.

Configuration
REQ-025 Macro WR_WLAST_CHECK_EN defined: error flag set on any W handshake where m_wlast != (beat_cnt == awlen); in RESP m_bresp SHALL be 2'b10 (SLVERR) if flag set, else slave bresp; flag cleared on entering IDLE.
REQ-026 Macro not defined: m_wlast ignored; m_bresp always equals selected slave bresp; no error flag present.

Verification
REQ-027 AW 0x0000_0100 len 0, one beat 0xDEAD_BEEF, s1 bresp 00 -> s1_awaddr 0x0000_0100, s1_wlast=1 on beat, m_bresp 00, s2 signals all 0.
REQ-028 AW 0x8000_0040 len 3, four beats, s2_wready toggling -> s2_awaddr 0x0000_0040, exactly 4 s2 W handshakes, s2_wlast only on 4th.
REQ-029 AW 0x8000_0000 and 0x7FFF_FFFC -> slave 2 addr 0x0 and slave 1 addr 0x7FFF_FFFC respectively.
REQ-030 rst asserted during DATA after beat 2 of len 7 -> all valids 0 same cycle, state IDLE, next AW routed cleanly.
REQ-031 WR_WLAST_CHECK_EN defined, len 1 with m_wlast=1 on beat 1, slave bresp 00 -> m_bresp 10; macro undefined -> m_bresp 00.
REQ-032 Slave bvalid held with m_bready=0 for 5 cycles -> m_bvalid held, m_awready 0, completes on m_bready=1.

Source files
------------

// File: rtl/axi_wr_router.sv
// Single-outstanding AXI write router: steers one AW/W/B transaction to slave 1 or slave 2.
// Optional WR_WLAST_CHECK_EN flags m_wlast disagreement and returns SLVERR.
module axi_wr_router #(
  parameter logic [31:0] S1_WIDTH = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] m_awaddr,
  input  logic [7:0]  m_awlen,
  input  logic        m_awvalid,
  output logic        m_awready,

  input  logic [31:0] m_wdata,
  input  logic [3:0]  m_wstrb,
  input  logic        m_wlast,
  input  logic        m_wvalid,
  output logic        m_wready,

  output logic [1:0]  m_bresp,
  output logic        m_bvalid,
  input  logic        m_bready,

  output logic [31:0] dec_wr_addr,
  input  logic        dec_s1_sel,
  input  logic        dec_s2_sel,
  input  logic [31:0] dec_s1_addr,
  input  logic [31:0] dec_s2_addr,

  output logic [31:0] s1_awaddr,
  output logic [7:0]  s1_awlen,
  output logic        s1_awvalid,
  input  logic        s1_awready,
  output logic [31:0] s1_wdata,
  output logic [3:0]  s1_wstrb,
  output logic        s1_wlast,
  output logic        s1_wvalid,
  input  logic        s1_wready,
  input  logic [1:0]  s1_bresp,
  input  logic        s1_bvalid,
  output logic        s1_bready,

  output logic [31:0] s2_awaddr,
  output logic [7:0]  s2_awlen,
  output logic        s2_awvalid,
  input  logic        s2_awready,
  output logic [31:0] s2_wdata,
  output logic [3:0]  s2_wstrb,
  output logic        s2_wlast,
  output logic        s2_wvalid,
  input  logic        s2_wready,
  input  logic [1:0]  s2_bresp,
  input  logic        s2_bvalid,
  output logic        s2_bready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        sel_q, sel_d;     // 1 selects slave 2
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  beat_q, beat_d;
  logic        err_q, err_d;

  logic in_addr, in_data, in_resp;
  logic s1_on, s2_on;
  logic aw_hs, sel_awready, w_hs, b_hs, last_beat;
  logic [1:0] sel_bresp;

  assign dec_wr_addr = m_awaddr;

  assign in_addr   = (state_q == ADDR);
  assign in_data   = (state_q == DATA);
  assign in_resp   = (state_q == RESP);
  assign s1_on     = ~sel_q;
  assign s2_on     = sel_q;
  assign last_beat = (beat_q == len_q);

  // Master-side handshakes and muxed slave returns.
  always_comb begin
    m_awready   = (state_q == IDLE) && !rst;
    sel_awready = sel_q ? s2_awready : s1_awready;
    m_wready    = in_data && (sel_q ? s2_wready : s1_wready);
    m_bvalid    = in_resp && (sel_q ? s2_bvalid : s1_bvalid);
    sel_bresp   = sel_q ? s2_bresp : s1_bresp;
    m_bresp     = 2'b00;
    if (in_resp) begin
      m_bresp = err_q ? 2'b10 : sel_bresp;
    end
    aw_hs = m_awvalid && m_awready;
    w_hs  = m_wvalid && m_wready;
    b_hs  = m_bvalid && m_bready;
  end

  // Slave-side outputs; the unselected slave sees all zeros.
  always_comb begin
    s1_awvalid = in_addr && s1_on;
    s2_awvalid = in_addr && s2_on;
    s1_awaddr  = s1_awvalid ? addr_q : 32'h0;
    s2_awaddr  = s2_awvalid ? addr_q : 32'h0;
    s1_awlen   = s1_awvalid ? len_q : 8'h0;
    s2_awlen   = s2_awvalid ? len_q : 8'h0;

    s1_wdata  = (in_data && s1_on) ? m_wdata : 32'h0;
    s2_wdata  = (in_data && s2_on) ? m_wdata : 32'h0;
    s1_wstrb  = (in_data && s1_on) ? m_wstrb : 4'h0;
    s2_wstrb  = (in_data && s2_on) ? m_wstrb : 4'h0;
    s1_wvalid = in_data && s1_on && m_wvalid;
    s2_wvalid = in_data && s2_on && m_wvalid;
    s1_wlast  = in_data && s1_on && last_beat;
    s2_wlast  = in_data && s2_on && last_beat;

    s1_bready = in_resp && s1_on && m_bready;
    s2_bready = in_resp && s2_on && m_bready;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (aw_hs) begin
          sel_d   = dec_s2_sel;
          addr_d  = dec_s2_sel ? dec_s2_addr : dec_s1_addr;
          len_d   = m_awlen;
          beat_d  = 8'h0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (sel_awready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
`ifdef WR_WLAST_CHECK_EN
          if (m_wlast != last_beat) begin
            err_d = 1'b1;
          end
`endif
          // Hold on the final beat so len 255 never wraps the counter.
          if (last_beat) begin
            state_d = RESP;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      RESP: begin
        if (b_hs) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      addr_q  <= 32'h0;
      len_q   <= 8'h0;
      beat_q  <= 8'h0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end

`ifdef WR_WLAST_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  logic unused_decode;
  assign unused_decode = dec_s1_sel ^ (m_awaddr >= S1_WIDTH);
`else
  assign err_q = 1'b0;

  // Routing trusts the decoder; these inputs carry no datapath role.
  logic unused_decode;
  assign unused_decode = dec_s1_sel ^ (m_awaddr >= S1_WIDTH) ^ m_wlast ^ err_d;
`endif

endmodule

// File: tb/tb_axi_wr_router.sv
// Scoreboard bench for axi_wr_router: stimulus queues expected AW/W/B, a monitor pops on handshakes.
module tb_axi_wr_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic        m_awvalid, m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast, m_wvalid, m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid, m_bready;
  logic [31:0] dec_wr_addr, dec_s1_addr, dec_s2_addr;
  logic        dec_s1_sel, dec_s2_sel;
  logic [31:0] s1_awaddr, s2_awaddr, s1_wdata, s2_wdata;
  logic [7:0]  s1_awlen, s2_awlen;
  logic [3:0]  s1_wstrb, s2_wstrb;
  logic [1:0]  s1_bresp, s2_bresp;
  logic        s1_awvalid, s1_awready, s1_wlast, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
  logic        s2_awvalid, s2_awready, s2_wlast, s2_wvalid, s2_wready, s2_bvalid, s2_bready;

`ifdef WR_WLAST_CHECK_EN
  localparam logic [1:0] ErrResp = 2'b10;
`else
  localparam logic [1:0] ErrResp = 2'b00;
`endif

  axi_wr_router #(.S1_WIDTH(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .dec_wr_addr(dec_wr_addr), .dec_s1_sel(dec_s1_sel), .dec_s2_sel(dec_s2_sel),
    .dec_s1_addr(dec_s1_addr), .dec_s2_addr(dec_s2_addr),
    .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awvalid(s1_awvalid),
    .s1_awready(s1_awready), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast),
    .s1_wvalid(s1_wvalid), .s1_wready(s1_wready), .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid),
    .s1_bready(s1_bready),
    .s2_awaddr(s2_awaddr), .s2_awlen(s2_awlen), .s2_awvalid(s2_awvalid),
    .s2_awready(s2_awready), .s2_wdata(s2_wdata), .s2_wstrb(s2_wstrb), .s2_wlast(s2_wlast),
    .s2_wvalid(s2_wvalid), .s2_wready(s2_wready), .s2_bresp(s2_bresp), .s2_bvalid(s2_bvalid),
    .s2_bready(s2_bready)
  );

  always #5 clk = ~clk;

  // Address decoder model: upper half goes to slave 2, rebased to zero.
  assign dec_s2_sel  = (dec_wr_addr >= 32'h8000_0000);
  assign dec_s1_sel  = ~dec_s2_sel;
  assign dec_s1_addr = dec_wr_addr;
  assign dec_s2_addr = dec_wr_addr - 32'h8000_0000;

  int checks = 0;
  int errors = 0;
  int s2_whs = 0;
  logic       toggle2 = 1'b0;
  logic [1:0] bresp_cfg = 2'b00;

  logic [40:0] aw_q[$];  // {sel, addr, len}
  logic [37:0] w_q[$];   // {sel, data, strb, last}
  logic [1:0]  b_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got handshake expected none", name);
  endtask

  // Monitor: compares every handshake against the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (s1_awvalid && s1_awready) begin
        if (aw_q.size() == 0) unexpected("aw_s1");
        else chk("aw_s1", {1'b0, s1_awaddr, s1_awlen}, aw_q.pop_front());
      end
      if (s2_awvalid && s2_awready) begin
        if (aw_q.size() == 0) unexpected("aw_s2");
        else chk("aw_s2", {1'b1, s2_awaddr, s2_awlen}, aw_q.pop_front());
      end
      if (s1_wvalid && s1_wready) begin
        if (w_q.size() == 0) unexpected("w_s1");
        else chk("w_s1", {1'b0, s1_wdata, s1_wstrb, s1_wlast}, w_q.pop_front());
      end
      if (s2_wvalid && s2_wready) begin
        s2_whs++;
        if (w_q.size() == 0) unexpected("w_s2");
        else chk("w_s2", {1'b1, s2_wdata, s2_wstrb, s2_wlast}, w_q.pop_front());
      end
      if (m_bvalid && m_bready) begin
        if (b_q.size() == 0) unexpected("b");
        else chk("bresp", m_bresp, b_q.pop_front());
      end
      chk("exclusive", (s1_awvalid | s1_wvalid | s1_bready) & (s2_awvalid | s2_wvalid | s2_bready),
          0);
      if (s1_awvalid | s1_wvalid | s1_bready)
        chk("s2_quiet", |{s2_awaddr, s2_awlen, s2_wdata, s2_wstrb, s2_wlast}, 0);
    end
  end

  // Slave responders: B follows the last W beat; slave 2 can throttle AW/W.
  logic l1, l2, b1, b2;
  initial begin
    s1_awready = 1'b1; s2_awready = 1'b1; s1_wready = 1'b1; s2_wready = 1'b1;
    s1_bvalid = 1'b0; s2_bvalid = 1'b0; s1_bresp = 2'b00; s2_bresp = 2'b00;
    forever begin
      @(negedge clk);
      l1 = s1_wvalid && s1_wready && s1_wlast;
      l2 = s2_wvalid && s2_wready && s2_wlast;
      b1 = s1_bvalid && s1_bready;
      b2 = s2_bvalid && s2_bready;
      @(posedge clk);
      #1;
      if (b1) begin s1_bvalid = 1'b0; s1_bresp = 2'b00; end
      if (b2) begin s2_bvalid = 1'b0; s2_bresp = 2'b00; end
      if (l1) begin s1_bvalid = 1'b1; s1_bresp = bresp_cfg; end
      if (l2) begin s2_bvalid = 1'b1; s2_bresp = bresp_cfg; end
      if (toggle2) begin
        s2_wready  = ~s2_wready;
        s2_awready = ~s2_awready;
      end else begin
        s2_wready  = 1'b1;
        s2_awready = 1'b1;
      end
    end
  end

  task automatic wait_hs(input int which, input string name);
    int n;
    logic ok;
    n = 0;
    forever begin
      @(negedge clk);
      case (which)
        0:       ok = m_awready;
        1:       ok = m_wready;
        default: ok = m_bvalid;
      endcase
      if (ok) break;
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL %s: got no handshake expected one within 300 cycles", name);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [31:0] addr, input logic [7:0] len, input logic esel,
                       input logic [31:0] eaddr);
    aw_q.push_back({esel, eaddr, len});
    m_awaddr  = addr;
    m_awlen   = len;
    m_awvalid = 1'b1;
    #1;
    chk("dec_wr_addr", dec_wr_addr, addr);
    wait_hs(0, "aw_wait");
    m_awvalid = 1'b0;
  endtask

  // mode 0: correct m_wlast; mode 1: m_wlast only on the first beat.
  task automatic do_w(input logic [7:0] len, input logic esel, input logic [31:0] data0,
                      input int mode, input int nbeats);
    logic       last;
    logic [3:0] strb;
    for (int i = 0; i < nbeats; i++) begin
      last = (i == int'(len));
      strb = ~4'(i);
      w_q.push_back({esel, data0 + 32'(i), strb, last});
      m_wdata  = data0 + 32'(i);
      m_wstrb  = strb;
      m_wlast  = (mode == 0) ? last : (i == 0);
      m_wvalid = 1'b1;
      wait_hs(1, "w_wait");
    end
    m_wvalid = 1'b0;
    m_wlast  = 1'b0;
  endtask

  task automatic do_b(input logic [1:0] eresp, input int hold);
    b_q.push_back(eresp);
    m_bready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("bvalid_held", m_bvalid, 1);
      chk("awready_in_resp", m_awready, 0);
      @(posedge clk);
      #1;
    end
    m_bready = 1'b1;
    wait_hs(2, "b_wait");
    m_bready = 1'b0;
    chk("awready_after_b", m_awready, 1);
  endtask

  task automatic txn(input logic [31:0] addr, input logic [7:0] len, input logic esel,
                     input logic [31:0] eaddr, input logic [31:0] data0, input logic [1:0] sresp,
                     input logic [1:0] eresp, input int hold);
    bresp_cfg = sresp;
    do_aw(addr, len, esel, eaddr);
    do_w(len, esel, data0, 0, int'(len) + 1);
    do_b(eresp, hold);
  endtask

  function automatic logic [8:0] valids();
    return {s1_awvalid, s1_wvalid, s1_bready, s2_awvalid, s2_wvalid, s2_bready,
            m_awready, m_wready, m_bvalid};
  endfunction

  initial begin
    int base;
    rst = 1'b0;
    m_awaddr = 32'h0; m_awlen = 8'h0; m_awvalid = 1'b0;
    m_wdata = 32'h0; m_wstrb = 4'h0; m_wlast = 1'b0; m_wvalid = 1'b0; m_bready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_valids", valids(), 0);
    chk("reset_bresp", m_bresp, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("awready_after_reset", m_awready, 1);
    @(posedge clk);
    #1;

    // Single beat to slave 1.
    txn(32'h0000_0100, 8'd0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 2'b00, 2'b00, 0);

    // Four beats to slave 2 with throttled ready.
    toggle2 = 1'b1;
    base = s2_whs;
    txn(32'h8000_0040, 8'd3, 1'b1, 32'h0000_0040, 32'h1111_0000, 2'b00, 2'b00, 0);
    chk("s2_w_handshakes", s2_whs - base, 4);
    toggle2 = 1'b0;

    // Region boundary.
    txn(32'h8000_0000, 8'd0, 1'b1, 32'h0000_0000, 32'h2222_0000, 2'b00, 2'b00, 0);
    txn(32'h7FFF_FFFC, 8'd0, 1'b0, 32'h7FFF_FFFC, 32'h3333_0000, 2'b00, 2'b00, 0);

    // Reset in the middle of a len 7 burst, after two beats.
    do_aw(32'h8000_0100, 8'd7, 1'b1, 32'h0000_0100);
    do_w(8'd7, 1'b1, 32'hA000_0000, 0, 2);
    rst = 1'b1;
    #1;
    chk("midreset_valids", valids(), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midreset_release", valids(), 9'b000000100);
    @(negedge clk);
    chk("midreset_idle", valids(), 9'b000000100);
    @(posedge clk);
    #1;
    txn(32'h0000_0200, 8'd1, 1'b0, 32'h0000_0200, 32'h4444_0000, 2'b00, 2'b00, 0);

    // Misplaced m_wlast.
    bresp_cfg = 2'b00;
    do_aw(32'h0000_0300, 8'd1, 1'b0, 32'h0000_0300);
    do_w(8'd1, 1'b0, 32'h5555_0000, 1, 2);
    do_b(ErrResp, 0);
    txn(32'h0000_0304, 8'd0, 1'b0, 32'h0000_0304, 32'h5555_1000, 2'b00, 2'b00, 0);

    // B stalled by the master for five cycles.
    txn(32'h8000_1000, 8'd2, 1'b1, 32'h0000_1000, 32'h6666_0000, 2'b01, 2'b01, 5);

    // Full-length burst.
    txn(32'h0000_1000, 8'd255, 1'b0, 32'h0000_1000, 32'h7700_0000, 2'b00, 2'b00, 0);

    repeat (3) @(negedge clk);
    chk("aw_q_drained", aw_q.size(), 0);
    chk("w_q_drained", w_q.size(), 0);
    chk("b_q_drained", b_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
